// File: rtl/ppa_arb_pkg.sv
// Shared types and the round-robin pick function for the ppa_arbiter slice.
// Everything is sized for the largest supported requester count (8).
package ppa_arb_pkg;

    localparam int PPA_W    = 32;
    localparam int NREQ_MAX = 8;
    localparam int ID_MAX_W = 3;

    typedef logic [ID_MAX_W-1:0] ppa_id_t;

    typedef struct packed {
        ppa_id_t          id;
        logic [PPA_W-1:0] a;
        logic [PPA_W-1:0] b;
    } ppa_op_t;

    typedef struct packed {
        ppa_id_t          id;
        logic [PPA_W-1:0] sum;
        logic             cout;
    } ppa_rsp_t;

    typedef struct packed {
        logic    found;
        ppa_id_t idx;
    } rr_pick_t;

    // Walks downward so the lowest offset from ptr is the last one written and wins.
    function automatic rr_pick_t rr_pick(input logic [NREQ_MAX-1:0] valid,
                                         input ppa_id_t ptr, input int n);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = NREQ_MAX - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % n;
            if (k < n && valid[j]) begin
                r.found = 1'b1;
                r.idx   = ppa_id_t'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_adder.sv
// Kogge-Stone parallel-prefix adder: sum = (a+b) mod 2^W, cout = carry out of bit W-1.
module cla_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int LVLS = $clog2(W);

    logic [W-1:0] gk, pk, gn, pn;

    always_comb begin
        gk = a & b;
        pk = a ^ b;
        gn = '0;
        pn = '0;
        for (int l = 0; l < LVLS; l++) begin
            gn = gk;
            pn = pk;
            for (int i = (1 << l); i < W; i++) begin
                gn[i] = gk[i] | (pk[i] & gk[i - (1 << l)]);
                pn[i] = pk[i] & pk[i - (1 << l)];
            end
            gk = gn;
            pk = pn;
        end
        // After the last level gk[i] is the carry out of bit i.
        sum  = (a ^ b) ^ {gk[W-2:0], 1'b0};
        cout = gk[W-1];
    end

endmodule

// File: rtl/ppa_rr_arb.sv
// Round-robin requester pick plus the registered rotation pointer.
// The pointer advances past the winner only on an actual accept.
module ppa_rr_arb
    import ppa_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] valid,
    input  logic            accept,
    output logic            found,
    output ppa_id_t         idx
);

    ppa_id_t  rr_ptr;
    rr_pick_t pick;

    always_comb pick = rr_pick(NREQ_MAX'(valid), rr_ptr, NREQ);

    assign found = pick.found;
    assign idx   = pick.idx;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (int'(pick.idx) == NREQ - 1) ? '0 : pick.idx + 1'b1;
        end
    end

endmodule

// File: rtl/ppa_arbiter.sv
// Round-robin arbiter sharing one cla_adder between NREQ requesters through a
// two-stage operand/result pipeline. Define PPA_ARB_CNT_EN to add grant_cnt.
module ppa_arbiter
    import ppa_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_cout
`ifdef PPA_ARB_CNT_EN
    ,
    output logic [NREQ*16-1:0]   grant_cnt
`endif
);

    logic             found;
    ppa_id_t          win;
    logic             accept, s1_free, s2_load;
    logic [PPA_W-1:0] sel_a, sel_b;
    logic [PPA_W-1:0] add_sum;
    logic             add_cout;

    logic     s1_v, s2_v;
    ppa_op_t  s1;
    ppa_rsp_t s2;

    ppa_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (req_valid),
        .accept (accept),
        .found  (found),
        .idx    (win)
    );

    assign s2_load = s1_v && (!s2_v || rsp_ready);
    assign s1_free = !s1_v || s2_load;
    // rst_n gates the handshake so nothing looks accepted while reset is held.
    assign accept  = rst_n && found && s1_free;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (int'(win) == i);
            if (int'(win) == i) begin
                sel_a = req_a[PPA_W*i +: PPA_W];
                sel_b = req_b[PPA_W*i +: PPA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (accept)       s1_v <= 1'b1;
            else if (s2_load) s1_v <= 1'b0;

            if (s2_load)        s2_v <= 1'b1;
            else if (rsp_ready) s2_v <= 1'b0;
        end
    end

    // NOTE: payload registers are deliberately not reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (accept)  s1 <= '{id: win, a: sel_a, b: sel_b};
        if (s2_load) s2 <= '{id: s1.id, sum: add_sum, cout: add_cout};
    end

    cla_adder #(.W(PPA_W)) u_add (
        .a    (s1.a),
        .b    (s1.b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Unreset payload is masked so the response fields read 0 whenever nothing is valid.
    assign rsp_valid = s2_v;
    assign rsp_id    = s2_v ? IDW'(s2.id) : '0;
    assign rsp_sum   = s2_v ? s2.sum      : '0;
    assign rsp_cout  = s2_v && s2.cout;

`ifdef PPA_ARB_CNT_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        logic [15:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (req_valid[i] && req_ready[i] && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end
        assign grant_cnt[16*i +: 16] = cnt;
    end
`endif

endmodule
